ram_x_seq_ctrl: RTL and testbench

//  Sequencer for one 225x32 single-port feature RAM (8-bit address, write when we=1, registered read

---
 rtl/ram_x_seq_ctrl_if.sv | 38 +++
 rtl/ram_x_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_ram_x_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_x_seq_ctrl_if.sv
// ram_x_seq_ctrl_if: load stream, replay stream, control and RAM port
// bundle of the feature-RAM sequencer. master = sequencer, slave = peers.
interface ram_x_seq_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          start;
  logic          clear;
  logic          busy;
  logic          done;
  logic          loaded;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic [7:0]    out_pass;
  logic          out_last;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_qin;
  logic [DW-1:0] ram_dout;

  modport master (
    input  in_valid, in_data, start, clear, ram_dout,
    output in_ready, busy, done, loaded,
    output out_valid, out_data, out_idx, out_pass, out_last,
    output ram_addr, ram_we, ram_qin
  );

  modport slave (
    output in_valid, in_data, start, clear, ram_dout,
    input  in_ready, busy, done, loaded,
    input  out_valid, out_data, out_idx, out_pass, out_last,
    input  ram_addr, ram_we, ram_qin
  );
endinterface

// File: rtl/ram_x_seq_ctrl.sv
// ram_x_seq_ctrl: loads one feature vector into a single-port RAM, then
// replays it NUM_PASSES times as a beat stream aligned with ram_dout.
// Ports: clk, rst (sync, active high), bus (ram_x_seq_ctrl_if.master):
//   in_valid/in_data/in_ready load stream; start/clear control;
//   busy/done/loaded status; out_valid/data/idx/pass/last replay stream;
//   ram_addr/ram_we/ram_qin/ram_dout RAM port.
module ram_x_seq_ctrl #(
  parameter int DEPTH      = 225,
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int NUM_PASSES = 4
) (
  input  logic             clk,
  input  logic             rst,
  ram_x_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_LOADED,
    S_STREAM
  } state_t;

  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
  localparam logic [7:0]    LAST_P = 8'(NUM_PASSES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    pass_q, pass_d;
  logic          fin_q, fin_d;
  logic          loaded_q, loaded_d;
  logic          issue;
  logic          final_issue;

  logic          busy_q, done_q;
  logic          ov_q, olast_q;
  logic [AW-1:0] oidx_q;
  logic [7:0]    opass_q;

  // fin marks the drain cycle: last read is in flight, no new issue.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_addr_d     = rd_addr_q;
    pass_d        = pass_q;
    fin_d         = fin_q;
    loaded_d      = loaded_q;
    issue         = 1'b0;
    bus.in_ready  = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_qin   = bus.in_data;
    unique case (state_q)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.ram_we   = bus.in_valid;
        bus.ram_addr = wr_cnt_q;
        if (bus.in_valid) begin
          if (wr_cnt_q == LAST_A) begin
            wr_cnt_d = '0;
            loaded_d = 1'b1;
            state_d  = S_LOADED;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      S_LOADED: begin
        if (bus.start) begin
          state_d   = S_STREAM;
          rd_addr_d = '0;
          pass_d    = '0;
          fin_d     = 1'b0;
        end
      end
      S_STREAM: begin
        bus.ram_addr = rd_addr_q;
        if (fin_q) begin
          state_d = S_LOADED;
          fin_d   = 1'b0;
        end else begin
          issue = 1'b1;
          if (rd_addr_q == LAST_A) begin
            rd_addr_d = '0;
            if (pass_q == LAST_P) fin_d = 1'b1;
            else pass_d = pass_q + 8'd1;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    if (bus.clear) begin
      state_d  = S_LOAD;
      wr_cnt_d = '0;
      loaded_d = 1'b0;
      fin_d    = 1'b0;
    end
  end

  assign final_issue = issue && (rd_addr_q == LAST_A)
                    && (pass_q == LAST_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
      pass_q    <= '0;
      fin_q     <= 1'b0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ov_q      <= 1'b0;
      oidx_q    <= '0;
      opass_q   <= '0;
      olast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_addr_q <= rd_addr_d;
      pass_q    <= pass_d;
      fin_q     <= fin_d;
      loaded_q  <= loaded_d;
      busy_q    <= (state_d == S_STREAM);
      done_q    <= final_issue && !bus.clear;
      ov_q      <= issue && !bus.clear;
      oidx_q    <= issue ? rd_addr_q : '0;
      opass_q   <= issue ? pass_q : '0;
      olast_q   <= issue && (rd_addr_q == LAST_A);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.loaded    = loaded_q;
  assign bus.out_valid = ov_q;
  assign bus.out_idx   = oidx_q;
  assign bus.out_pass  = opass_q;
  assign bus.out_last  = olast_q;
  assign bus.out_data  = bus.ram_dout;

endmodule

// File: tb/tb_ram_x_seq_ctrl.sv
// tb_ram_x_seq_ctrl: directed bench for ram_x_seq_ctrl with a
// behavioural 256x32 registered-read RAM, NUM_PASSES = 2.
module tb_ram_x_seq_ctrl;
  localparam int DEPTH = 225;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int NP    = 2;
  localparam int NB    = DEPTH * NP;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt;
  int   viol;

  ram_x_seq_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  ram_x_seq_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .NUM_PASSES(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_qin;
    else bus.ram_dout <= mem[bus.ram_addr];
  end

  logic [63:0] rec [0:NB-1];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] val(input int mode, input int i);
    case (mode)
      0: return 32'(3 * i);
      1: return 32'd7;
      default: return 32'(1000 + i);
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk(tag, {bus.busy, bus.done, bus.loaded, bus.out_valid,
              bus.out_idx, bus.out_pass, bus.out_last, bus.in_ready},
        {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1});
  endtask

  task automatic load(input int from, input int to, input int mode,
                      input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          bus.in_valid = 1'b0;
          bus.in_data  = $urandom;
          @(negedge clk);
          we_cnt += int'(bus.ram_we);
          nxt();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = val(mode, i);
      @(negedge clk);
      we_cnt += int'(bus.ram_we);
      chk("load_beat",
          {bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_qin},
          {1'b1, 1'b1, 8'(i), val(mode, i)});
      nxt();
    end
    bus.in_valid = 1'b0;
  endtask

  // recmode: 0 none, 1 record beats, 2 compare with recorded run
  task automatic stream(input int mode, input int recmode);
    logic [63:0] obs;
    logic [63:0] exp;
    int          b;
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    for (int k = 1; k <= NB + 2; k++) begin
      @(negedge clk);
      if (bus.out_valid)
        obs = {1'b1, bus.out_idx, bus.out_pass, bus.out_last,
               bus.done, bus.busy, bus.out_data};
      else
        obs = {1'b0, 8'd0, 8'd0, 1'b0, bus.done, bus.busy, 32'd0};
      b = k - 2;
      if (k >= 2 && k <= NB + 1)
        exp = {1'b1, 8'(b % DEPTH), 8'(b / DEPTH),
               (b % DEPTH) == DEPTH - 1, k == NB + 1, 1'b1,
               val(mode, b % DEPTH)};
      else
        exp = {1'b0, 8'd0, 8'd0, 1'b0, 1'b0, k == 1, 32'd0};
      chk("stream_beat", obs, exp);
      if (k >= 2 && k <= NB + 1) begin
        if (recmode == 1) rec[b] = obs;
        if (recmode == 2) chk("replay_same", obs, rec[b]);
      end
      nxt();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.start    = 1'b0;
    bus.clear    = 1'b0;
    we_cnt       = 0;
    repeat (3) nxt();
    @(negedge clk);
    chk_reset("reset_state");
    nxt();
    rst = 1'b0;

    load(0, 60, 2, 1'b0);
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    nxt();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_reset("rst_midload");
    chk("rst_ram_port", {bus.ram_we, bus.ram_addr}, 9'd0);
    nxt();

    we_cnt = 0;
    load(0, DEPTH, 0, 1'b0);
    bus.in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      we_cnt += int'(bus.ram_we);
      if (j == 0)
        chk("loaded_flags", {bus.in_ready, bus.loaded}, 2'b01);
      nxt();
    end
    bus.in_valid = 1'b0;
    chk("we_count", we_cnt, DEPTH);

    stream(0, 1);
    stream(0, 2);

    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    repeat (51) nxt();
    bus.clear = 1'b1;
    @(negedge clk);
    chk("pre_clear_beat", {bus.out_valid, bus.out_idx, bus.out_pass},
        {1'b1, 8'd50, 8'd0});
    nxt();
    bus.clear = 1'b0;
    viol = 0;
    for (int j = 0; j < 460; j++) begin
      @(negedge clk);
      if (bus.out_valid || bus.done) viol++;
      nxt();
    end
    chk("post_clear_quiet", viol, 0);
    @(negedge clk);
    chk("post_clear_state", {bus.loaded, bus.in_ready, bus.busy},
        3'b010);
    nxt();

    load(0, 100, 1, 1'b0);
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("start_in_load",
          {bus.out_valid, bus.busy, bus.loaded, bus.in_ready}, 4'b0001);
      nxt();
    end
    load(100, DEPTH, 1, 1'b1);
    @(negedge clk);
    chk("reload_done", {bus.in_ready, bus.loaded}, 2'b01);
    nxt();
    stream(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
